// File: rtl/wave_probe_pkg.sv
// Shared constants for the wave_probe_sel register block.
// Latency: n/a (constants only).
// Backpressure: n/a.
package wave_probe_pkg;

  // Byte offsets of the configuration registers (only paddr[7:0] is decoded).
  localparam logic [7:0] REG_SEL   = 8'h00;
  localparam logic [7:0] REG_DECIM = 8'h04;
  localparam logic [7:0] REG_MASK  = 8'h08;
  localparam logic [7:0] REG_CTRL  = 8'h0C;
  localparam logic [7:0] REG_INFO  = 8'h10;

  // Upper half of INFO, lets software identify the block ("WP").
  localparam logic [15:0] INFO_MAGIC = 16'h5750;

  // Bit position of the freeze control inside CTRL.
  localparam int FREEZE_BIT = 0;

endpackage

// File: rtl/wave_bit_sync.sv
// Multi-flop synchroniser chain for a whole bus; Stages=0 degenerates to a wire.
// Latency: Stages cycles din -> dout.
// Backpressure: none, samples every cycle.
// Ports: clk/rst_n (async active-low), din (asynchronous bus), dout (synchronised bus).
module wave_bit_sync #(
  parameter int Stages = 2,
  parameter int Width  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [Width-1:0] din,
  output logic [Width-1:0] dout
);

  if (Stages == 0) begin : g_bypass
    assign dout = din;

    // Clock and reset have no load in bypass mode.
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst_n;
  end else begin : g_sync
    logic [Width-1:0] sync_q [Stages];
    logic [Width-1:0] sync_d [Stages];

    always_comb begin
      sync_d[0] = din;
      for (int i = 1; i < Stages; i++) begin
        sync_d[i] = sync_q[i-1];
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < Stages; i++) begin
          sync_q[i] <= '0;
        end
      end else begin
        for (int i = 0; i < Stages; i++) begin
          sync_q[i] <= sync_d[i];
        end
      end
    end

    assign dout = sync_q[Stages-1];
  end

endmodule

// File: rtl/wave_probe_sel.sv
// APB-configured probe front end: synchronise, select one group, mask, decimate.
// Latency: SyncStages+2 cycles probe_data -> dout_data (DECIM<=1, not frozen).
// Backpressure: none on the datapath; APB always answers with exactly one wait state.
// Ports: clk, rst_n (async active-low); probe_data (NumGroups*DataBits);
//        cfg_* APB slave (psel pre-gated by address window);
//        dout_data / dout_sample towards wave_capture.
module wave_probe_sel
  import wave_probe_pkg::*;
#(
  parameter int DataBits   = 32,
  parameter int NumGroups  = 4,
  parameter int SyncStages = 2,
  parameter int DecimBits  = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NumGroups*DataBits-1:0] probe_data,
  input  logic [31:0]                   cfg_paddr,
  input  logic                          cfg_pwrite,
  input  logic [31:0]                   cfg_pwdata,
  input  logic                          cfg_psel,
  input  logic                          cfg_penable,
  output logic                          cfg_pready,
  output logic [31:0]                   cfg_prdata,
  output logic                          cfg_pslverr,
  output logic [DataBits-1:0]           dout_data,
  output logic                          dout_sample
);

  logic [NumGroups*DataBits-1:0] probe_sync;

  logic [3:0]           sel_q,     sel_d;
  logic [DecimBits-1:0] decim_q,   decim_d;
  logic [DecimBits-1:0] cnt_q,     cnt_d;
  logic [DataBits-1:0]  mask_q,    mask_d;
  logic                 freeze_q,  freeze_d;
  logic [DataBits-1:0]  mux_q,     mux_d;
  logic [DataBits-1:0]  dout_q,    dout_d;
  logic                 sample_q,  sample_d;
  logic                 pready_q,  pready_d;
  logic [31:0]          prdata_q,  prdata_d;
  logic                 pslverr_q, pslverr_d;

  logic                 acc_first;
  logic                 acc_err;
  logic                 cnt_clr;
  logic [31:0]          rd_word;

  logic unused_paddr;
  assign unused_paddr = ^cfg_paddr[31:8];

  wave_bit_sync #(
    .Stages (SyncStages),
    .Width  (NumGroups*DataBits)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (probe_data),
    .dout  (probe_sync)
  );

  // APB slave. The first access cycle decodes the transfer and registers the
  // response, so pready rises one cycle later; register writes land on that
  // same edge, i.e. new values are live during the pready cycle.
  always_comb begin
    sel_d     = sel_q;
    decim_d   = decim_q;
    mask_d    = mask_q;
    freeze_d  = freeze_q;
    pready_d  = 1'b0;
    prdata_d  = '0;
    pslverr_d = 1'b0;
    acc_err   = 1'b0;
    cnt_clr   = 1'b0;
    rd_word   = '0;

    // pready_q gating stops a held access phase from being decoded twice.
    acc_first = cfg_psel && cfg_penable && !pready_q;

    if (acc_first) begin
      pready_d = 1'b1;
      case (cfg_paddr[7:0])
        REG_SEL: begin
          rd_word = 32'(sel_q);
          if (cfg_pwrite) begin
            if (cfg_pwdata >= 32'(NumGroups)) acc_err = 1'b1;
            else                              sel_d   = cfg_pwdata[3:0];
          end
        end
        REG_DECIM: begin
          rd_word = 32'(decim_q);
          if (cfg_pwrite) begin
            decim_d = cfg_pwdata[DecimBits-1:0];
            cnt_clr = 1'b1;
          end
        end
        REG_MASK: begin
          rd_word = 32'(mask_q);
          if (cfg_pwrite) mask_d = cfg_pwdata[DataBits-1:0];
        end
        REG_CTRL: begin
          rd_word = 32'(freeze_q) << FREEZE_BIT;
          if (cfg_pwrite) freeze_d = cfg_pwdata[FREEZE_BIT];
        end
        REG_INFO: begin
          rd_word = {INFO_MAGIC, 8'(NumGroups), 8'(DataBits)};
          if (cfg_pwrite) acc_err = 1'b1;
        end
        // Unmapped and unaligned offsets both land here.
        default: acc_err = 1'b1;
      endcase
      pslverr_d = acc_err;
      prdata_d  = (cfg_pwrite || acc_err) ? 32'h0 : rd_word;
    end
  end

  // Decimating datapath. DECIM of 0 or 1 keeps the counter at 0 so every
  // cycle samples; the >= compare also keeps it bounded at the maximum DECIM.
  always_comb begin
    mux_d = '0;
    for (int g = 0; g < NumGroups; g++) begin
      if (sel_q == 4'(g)) mux_d = probe_sync[g*DataBits +: DataBits];
    end

    if (cnt_clr || decim_q <= DecimBits'(1) || cnt_q >= decim_q - DecimBits'(1)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + DecimBits'(1);
    end

    sample_d = (cnt_q == '0) && !freeze_q;
    dout_d   = sample_d ? (mux_q & mask_q) : dout_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q     <= '0;
      decim_q   <= DecimBits'(1);
      cnt_q     <= '0;
      mask_q    <= '1;
      freeze_q  <= 1'b0;
      mux_q     <= '0;
      dout_q    <= '0;
      sample_q  <= 1'b0;
      pready_q  <= 1'b0;
      prdata_q  <= '0;
      pslverr_q <= 1'b0;
    end else begin
      sel_q     <= sel_d;
      decim_q   <= decim_d;
      cnt_q     <= cnt_d;
      mask_q    <= mask_d;
      freeze_q  <= freeze_d;
      mux_q     <= mux_d;
      dout_q    <= dout_d;
      sample_q  <= sample_d;
      pready_q  <= pready_d;
      prdata_q  <= prdata_d;
      pslverr_q <= pslverr_d;
    end
  end

  assign cfg_pready  = pready_q;
  assign cfg_prdata  = prdata_q;
  assign cfg_pslverr = pslverr_q;
  assign dout_data   = dout_q;
  assign dout_sample = sample_q;

endmodule

// File: tb/tb_wave_probe_sel.sv
// Directed self-checking bench for wave_probe_sel.
// Latency: n/a.
// Backpressure: n/a.
module tb_wave_probe_sel;

  logic         clk;
  logic         rst_n;
  logic [127:0] probe_data;
  logic [31:0]  paddr;
  logic         pwrite;
  logic [31:0]  pwdata;
  logic         psel;
  logic         penable;
  logic         pready;
  logic [31:0]  prdata;
  logic         pslverr;
  logic [31:0]  dout_data;
  logic         dout_sample;

  logic [31:0]  grp0, grp1, grp2_static, grp3, probe_cnt;
  logic         inc_en;
  int           errors;
  int           checks;
  logic [31:0]  prev;

  assign probe_data = {grp3, (inc_en ? probe_cnt : grp2_static), grp1, grp0};

  wave_probe_sel #(
    .DataBits   (32),
    .NumGroups  (4),
    .SyncStages (2),
    .DecimBits  (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .probe_data  (probe_data),
    .cfg_paddr   (paddr),
    .cfg_pwrite  (pwrite),
    .cfg_pwdata  (pwdata),
    .cfg_psel    (psel),
    .cfg_penable (penable),
    .cfg_pready  (pready),
    .cfg_prdata  (prdata),
    .cfg_pslverr (pslverr),
    .dout_data   (dout_data),
    .dout_sample (dout_sample)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Incrementing probe source for the decimation checks.
  initial begin
    probe_cnt = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      if (inc_en) probe_cnt = probe_cnt + 32'd1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic apb_xfer(input logic wr_en, input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = wr_en; paddr = addr; pwdata = wdata;
    @(posedge clk); #1;
    penable = 1'b1;
    @(negedge clk);
    check("pready_wait_state", 64'(pready), 64'(1'b0));
    @(negedge clk);
    check("pready_ack", 64'(pready), 64'(1'b1));
    rdata = prdata;
    err   = pslverr;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    @(negedge clk);
    check("apb_idle_after", {30'h0, pready, pslverr, prdata}, 64'h0);
  endtask

  task automatic wr(input string tag, input logic [31:0] addr, input logic [31:0] data,
                    input logic exp_err);
    logic [31:0] rd_v;
    logic        err_v;
    apb_xfer(1'b1, addr, data, rd_v, err_v);
    check({tag, "_pslverr"}, 64'(err_v), 64'(exp_err));
  endtask

  task automatic rd(input string tag, input logic [31:0] addr, input logic [31:0] exp_data,
                    input logic exp_err);
    logic [31:0] rd_v;
    logic        err_v;
    apb_xfer(1'b0, addr, 32'h0, rd_v, err_v);
    check({tag, "_prdata"}, 64'(rd_v), 64'(exp_data));
    check({tag, "_pslverr"}, 64'(err_v), 64'(exp_err));
  endtask

  initial begin
    errors = 0; checks = 0;
    inc_en = 1'b0;
    grp0 = 32'h1111_0000; grp1 = 32'h2222_0001; grp2_static = 32'hA5A5_0002; grp3 = 32'h3C3C_0003;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = 32'h0; pwdata = 32'h0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;

    // Reset state
    @(negedge clk);
    check("reset_outputs", {dout_data, dout_sample, pready, pslverr}, 64'h0);
    check("reset_prdata", 64'(prdata), 64'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Identification and reset register values
    rd("info", 32'h10, 32'h5750_0420, 1'b0);
    rd("decim_reset", 32'h04, 32'h1, 1'b0);
    rd("mask_reset", 32'h08, 32'hFFFF_FFFF, 1'b0);
    rd("sel_reset", 32'h00, 32'h0, 1'b0);
    check("dout_group0", 64'(dout_data), 64'h1111_0000);

    // Group select: visible two cycles after the commit (pready) cycle
    wr("sel_2", 32'h00, 32'h2, 1'b0);
    check("sel_not_yet", 64'(dout_data), 64'h1111_0000);
    @(negedge clk);
    check("sel_group2", 64'(dout_data), 64'hA5A5_0002);
    wr("sel_4_bad", 32'h00, 32'h4, 1'b1);
    rd("sel_kept", 32'h00, 32'h2, 1'b0);

    // Decimation by 5 on an incrementing probe
    inc_en = 1'b1;
    repeat (4) @(negedge clk);
    wr("decim_5", 32'h04, 32'd5, 1'b0);
    check("decim5_first", 64'(dout_sample), 64'h1);
    prev = dout_data;
    for (int p = 0; p < 2; p++) begin
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        check("decim5_gap", 64'(dout_sample), 64'h0);
      end
      @(negedge clk);
      check("decim5_pulse", 64'(dout_sample), 64'h1);
      check("decim5_delta", 64'(dout_data - prev), 64'd5);
      prev = dout_data;
    end

    // Rewrite DECIM mid-run: sample next cycle, then every 3
    repeat (2) @(negedge clk);
    wr("decim_3", 32'h04, 32'd3, 1'b0);
    check("decim3_first", 64'(dout_sample), 64'h1);
    prev = dout_data;
    for (int p = 0; p < 2; p++) begin
      for (int k = 0; k < 2; k++) begin
        @(negedge clk);
        check("decim3_gap", 64'(dout_sample), 64'h0);
      end
      @(negedge clk);
      check("decim3_pulse", 64'(dout_sample), 64'h1);
      check("decim3_delta", 64'(dout_data - prev), 64'd3);
      prev = dout_data;
    end

    // DECIM=0 samples every cycle; mask applied on sample
    inc_en = 1'b0;
    grp2_static = 32'h1234_5678;
    wr("decim_0", 32'h04, 32'd0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("decim0_every", 64'(dout_sample), 64'h1);
    end
    wr("mask_ffff", 32'h08, 32'h0000_FFFF, 1'b0);
    repeat (6) @(negedge clk);
    check("masked_data", {31'h0, dout_sample, dout_data}, {31'h0, 1'b1, 32'h0000_5678});

    // Freeze holds output while the probe changes
    wr("freeze_on", 32'h0C, 32'h1, 1'b0);
    check("freeze_first", 64'(dout_sample), 64'h0);
    grp2_static = 32'h0BAD_F00D;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check("freeze_hold", {31'h0, dout_sample, dout_data}, {31'h0, 1'b0, 32'h0000_5678});
    end
    rd("ctrl_read", 32'h0C, 32'h1, 1'b0);
    wr("freeze_off", 32'h0C, 32'h0, 1'b0);
    repeat (6) @(negedge clk);
    check("freeze_resume", {31'h0, dout_sample, dout_data}, {31'h0, 1'b1, 32'h0000_F00D});

    // Error responses
    wr("info_write", 32'h10, 32'hDEAD_BEEF, 1'b1);
    rd("info_after_write", 32'h10, 32'h5750_0420, 1'b0);
    rd("unmapped_14", 32'h14, 32'h0, 1'b1);
    rd("unaligned_02", 32'h02, 32'h0, 1'b1);
    wr("unaligned_wr_09", 32'h09, 32'h0, 1'b1);
    rd("mask_unchanged", 32'h08, 32'h0000_FFFF, 1'b0);

    // Reset during the wait-state cycle of a MASK write aborts it
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h08; pwdata = 32'h0000_00FF;
    @(posedge clk); #1;
    penable = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("abort_async_outputs", {dout_data, dout_sample, pready, pslverr}, 64'h0);
    check("abort_async_prdata", 64'(prdata), 64'h0);
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_release_outputs", {dout_data, 1'b0, pready, pslverr}, 64'h0);
    check("abort_release_prdata", 64'(prdata), 64'h0);
    rd("abort_mask", 32'h08, 32'hFFFF_FFFF, 1'b0);
    rd("abort_sel", 32'h00, 32'h0, 1'b0);
    rd("abort_decim", 32'h04, 32'h1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
